butterfly_sched: RTL
====================

BUTTERFLY_SCHED -- requirements
Module: butterfly_sched

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 7, meaning butterfly passes per transform run.
REQ-002 SHALL have parameter BEATS, default 8, meaning array issues (memory rows) per pass.
REQ-003 SHALL have parameter LUT_SIZE, default 1360, meaning twiddle-table depth per lane.
REQ-004 SHALL have parameter BF_LATENCY, default 2, meaning cycles from array inputs to array outputs.
REQ-005 SHALL have parameter RD_LATENCY, default 1, meaning cycles from rd_en to row data valid at the array.
REQ-006 SHALL have parameter MUL_W_IDX, default 0, meaning twiddle index used for every beat in multiply runs.
REQ-007 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-008 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port start, input, 1, single-cycle run request.
REQ-010 SHALL have port run_mode, input, 1, 0 = NTT run, 1 = pointwise-multiply run; sampled with start.
REQ-011 SHALL have port busy, output, 1, high while a run is in progress.
REQ-012 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port rd_en / rd_addr, output, 1 / $clog2(BEATS), row read strobe and address.
REQ-014 SHALL have port bf_mode, output, 1, array mode (0 butterfly, 1 multiply B).
REQ-015 SHALL have port w_idx, output, $clog2(LUT_SIZE)+1, twiddle index aligned with rd_en.
REQ-016 SHALL have port wr_en / wr_addr, output, 1 / $clog2(BEATS), result write strobe and address.
REQ-017 SHALL have port stage, output, $clog2(NUM_STAGES)+1, current pass number.

Function
REQ-018 SHALL implement states IDLE, ISSUE, DRAIN; IDLE->ISSUE on start, ISSUE->DRAIN after beat BEATS-1, DRAIN->ISSUE (next pass) or ->IDLE (last pass) in the cycle of the final wr_en of the pass.
REQ-019 SHALL sample start in IDLE only; start while busy SHALL be ignored.
REQ-020 SHALL assert rd_en for exactly BEATS consecutive ISSUE cycles, rd_addr 0..BEATS-1 ascending, starting the cycle after start.
REQ-021 SHALL, in NTT runs, present w_idx = stage*BEATS + beat with rd_en; counter starts at 0 per run and never wraps.
REQ-022 SHALL, in multiply runs, execute exactly one pass with w_idx = MUL_W_IDX on every beat.
REQ-023 SHALL hold bf_mode = run_mode for the whole run; 0 in IDLE.
REQ-024 SHALL assert wr_en/wr_addr exactly D = RD_LATENCY + BF_LATENCY cycles after each rd_en/rd_addr, via a D-deep shift register.
REQ-025 SHALL issue the first read of pass s+1 no earlier than the cycle after the last write of pass s (no read-after-write overlap).
REQ-026 SHALL pulse done and drop busy in the cycle after the final wr_en of the run.
REQ-027 SHALL hold w_idx, rd_addr, wr_addr at 0 when their strobes are low.
REQ-028 SHALL fail elaboration if NUM_STAGES*BEATS > LUT_SIZE or MUL_W_IDX >= LUT_SIZE.

Reset
REQ-029 SHALL on reset low force state IDLE and all outputs (busy, done, rd_en, rd_addr, bf_mode, w_idx, wr_en, wr_addr, stage) to 0 immediately.
REQ-030 SHALL on reset mid-run discard all in-flight write-delay entries; no wr_en after reset release.

Structure
REQ-031 SHALL place the state encoding and the D-derivation function in a shared package ntt_ctrl_pkg.
REQ-032 SHALL contain one sub-module, delay_line (width, depth params), for the wr_en/wr_addr alignment.

Verification (NUM_STAGES=2, BEATS=4, BF_LATENCY=2, RD_LATENCY=1; start in cycle 0)
REQ-033 SHALL check NTT run: rd_en cycles 1-4 w_idx 0-3, wr_en 4-7, rd_en 8-11 w_idx 4-7, wr_en 11-14, done at 15.
REQ-034 SHALL check multiply run, MUL_W_IDX=5: bf_mode=1, rd_en 1-4 all w_idx=5, wr_en 4-7, done at 8.
REQ-035 SHALL check start re-pulsed at cycle 6 of an NTT run -> timing identical to REQ-033, single done.
REQ-036 SHALL check reset low at cycle 10 -> all outputs 0 that cycle, no wr_en after release, next start runs cleanly.
REQ-037 SHALL check back-to-back runs: start at done cycle ignored (busy low only after), start at cycle 16 -> rd_en from 17.

Source files
------------

// File: rtl/ntt_ctrl_pkg.sv
// Shared definitions for the NTT butterfly-array controllers: scheduler state
// encoding and the read-to-write latency derivation.
package ntt_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } sched_state_e;

  // Cycles from a row read strobe to the matching result write strobe.
  function automatic int unsigned wr_delay(input int unsigned rd_latency,
                                           input int unsigned bf_latency);
    return rd_latency + bf_latency;
  endfunction

endpackage

// File: rtl/delay_line.sv
// Fixed-depth shift register; every stage clears on reset so nothing in flight
// survives a reset.
module delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/butterfly_sched.sv
// Pass scheduler for the butterfly array: issues row reads with twiddle
// indices, aligns result writes, and sequences NTT or single-pass multiply runs.
module butterfly_sched
  import ntt_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 7,
  parameter int unsigned BEATS      = 8,
  parameter int unsigned LUT_SIZE   = 1360,
  parameter int unsigned BF_LATENCY = 2,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned MUL_W_IDX  = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          run_mode,
  output logic                          busy,
  output logic                          done,
  output logic                          rd_en,
  output logic [$clog2(BEATS)-1:0]      rd_addr,
  output logic                          bf_mode,
  output logic [$clog2(LUT_SIZE):0]     w_idx,
  output logic                          wr_en,
  output logic [$clog2(BEATS)-1:0]      wr_addr,
  output logic [$clog2(NUM_STAGES):0]   stage
);

  localparam int unsigned AW = $clog2(BEATS);
  localparam int unsigned WW = $clog2(LUT_SIZE) + 1;
  localparam int unsigned SW = $clog2(NUM_STAGES) + 1;
  localparam int unsigned D  = wr_delay(RD_LATENCY, BF_LATENCY);

  localparam logic [AW-1:0] LAST_BEAT  = AW'(BEATS - 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);
  localparam logic [WW-1:0] MUL_IDX    = WW'(MUL_W_IDX);

  if (NUM_STAGES * BEATS > LUT_SIZE) begin : g_lut_depth_chk
    $error("butterfly_sched: NUM_STAGES*BEATS exceeds LUT_SIZE");
  end
  if (MUL_W_IDX >= LUT_SIZE) begin : g_mul_idx_chk
    $error("butterfly_sched: MUL_W_IDX outside twiddle table");
  end
  if (D == 0) begin : g_delay_chk
    $error("butterfly_sched: read-to-write delay must be at least one cycle");
  end

  sched_state_e    state_q, state_n;
  logic [AW-1:0]   beat_q, beat_n;
  logic [SW-1:0]   stage_q, stage_n;
  logic [WW-1:0]   w_cnt_q, w_cnt_n;
  logic            mode_q, mode_n;
  logic            done_q, done_n;
  logic            last_wr;
  logic            last_pass;
  logic [AW:0]     wr_pipe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      stage_q <= '0;
      w_cnt_q <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      beat_q  <= beat_n;
      stage_q <= stage_n;
      w_cnt_q <= w_cnt_n;
      mode_q  <= mode_n;
      done_q  <= done_n;
    end
  end

  assign last_wr   = wr_en && (wr_addr == LAST_BEAT);
  assign last_pass = mode_q || (stage_q == LAST_STAGE);

  always_comb begin
    state_n = state_q;
    beat_n  = beat_q;
    stage_n = stage_q;
    w_cnt_n = w_cnt_q;
    mode_n  = mode_q;
    done_n  = 1'b0;
    rd_en   = 1'b0;
    rd_addr = '0;
    w_idx   = '0;
    unique case (state_q)
      IDLE: begin
        // The done cycle already reads as idle, but a start there is not taken.
        if (start && !done_q) begin
          state_n = ISSUE;
          beat_n  = '0;
          stage_n = '0;
          w_cnt_n = '0;
          mode_n  = run_mode;
        end
      end
      ISSUE: begin
        rd_en   = 1'b1;
        rd_addr = beat_q;
        w_idx   = mode_q ? MUL_IDX : w_cnt_q;
        if (!mode_q) w_cnt_n = w_cnt_q + WW'(1);
        if (beat_q == LAST_BEAT) begin
          beat_n  = '0;
          state_n = DRAIN;
        end else begin
          beat_n = beat_q + AW'(1);
        end
      end
      DRAIN: begin
        // Next pass reads begin only once the final write of this pass is out.
        if (last_wr) begin
          if (last_pass) begin
            state_n = IDLE;
            stage_n = '0;
            mode_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            state_n = ISSUE;
            stage_n = stage_q + SW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Address travels with its strobe; both are zero when no read is issued.
  delay_line #(
    .WIDTH(AW + 1),
    .DEPTH(D)
  ) u_wr_delay (
    .clk  (clk),
    .reset(reset),
    .din  ({rd_en, rd_addr}),
    .dout (wr_pipe)
  );

  assign wr_en   = wr_pipe[AW];
  assign wr_addr = wr_pipe[AW-1:0];

  assign busy    = (state_q != IDLE);
  assign bf_mode = busy && mode_q;
  assign done    = done_q;
  assign stage   = stage_q;

endmodule
